// File: rtl/turn_request_latch.sv
// Left-turn request front end: per-direction sensor qualification, sticky
// request latches cleared by the serving phase, and served-phase counters.

module turn_press_detect #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic res,
    input  logic btn,
    output logic press
);

    localparam logic [31:0] LAST_COUNT = 32'(DEBOUNCE_CYCLES - 1);

    logic        sync_q1;
    logic        sync_q2;
    logic        stable;
    logic        stable_d;
    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            sync_q1  <= btn;
            sync_q2  <= sync_q1;
            stable_d <= stable;
            // Any return to the stable level before the count expires
            // discards the excursion as a glitch.
            if (sync_q2 == stable) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                stable <= sync_q2;
                count  <= '0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    // Only presses matter; releases are deliberately ignored downstream.
    assign press = stable & ~stable_d;

endmodule

module turn_request_slot #(
    parameter logic [3:0] S_SERVE   = 4'd6,
    parameter logic [3:0] S_HOLD    = 4'd7,
    parameter logic [3:0] S_INITOFF = 4'd10,
    parameter logic [3:0] S_INITON  = 4'd11
) (
    input  logic       clk,
    input  logic       res,
    input  logic [3:0] state,
    input  logic [3:0] prev_state,
    input  logic       press,
    output logic       req,
    output logic [7:0] served
);

    always_ff @(posedge clk) begin
        if (res) begin
            req    <= 1'b0;
            served <= '0;
        end else begin
            // Clear beats set: a press coinciding with init or serve is lost.
            if (state == S_INITOFF || state == S_INITON) begin
                req <= 1'b0;
            end else if (state == S_SERVE) begin
                req <= 1'b0;
            end else if (state == S_HOLD) begin
                req <= req;
            end else if (press) begin
                req <= 1'b1;
            end

            if (state == S_SERVE && prev_state != S_SERVE) begin
                served <= served + 8'd1;
            end
        end
    end

endmodule

module turn_request_latch #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [3:0] S_MTGSR         = 4'd6,
    parameter logic [3:0] S_MTYSR         = 4'd7,
    parameter logic [3:0] S_MRSTG         = 4'd8,
    parameter logic [3:0] S_MRSTY         = 4'd9,
    parameter logic [3:0] S_INITOFF       = 4'd10,
    parameter logic [3:0] S_INITON        = 4'd11
) (
    input  logic       clk,
    input  logic       res,
    input  logic       mainBtn,
    input  logic       sideBtn,
    input  logic [3:0] state,
    output logic       MLTReg,
    output logic       SLTReg,
    output logic [7:0] mainServed,
    output logic [7:0] sideServed
);

    logic [3:0] prev_state;
    logic       main_press;
    logic       side_press;

    always_ff @(posedge clk) begin
        if (res) begin
            prev_state <= '0;
        end else begin
            prev_state <= state;
        end
    end

    turn_press_detect #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_main_detect (
        .clk  (clk),
        .res  (res),
        .btn  (mainBtn),
        .press(main_press)
    );

    turn_press_detect #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_side_detect (
        .clk  (clk),
        .res  (res),
        .btn  (sideBtn),
        .press(side_press)
    );

    turn_request_slot #(
        .S_SERVE  (S_MTGSR),
        .S_HOLD   (S_MTYSR),
        .S_INITOFF(S_INITOFF),
        .S_INITON (S_INITON)
    ) u_main_slot (
        .clk       (clk),
        .res       (res),
        .state     (state),
        .prev_state(prev_state),
        .press     (main_press),
        .req       (MLTReg),
        .served    (mainServed)
    );

    turn_request_slot #(
        .S_SERVE  (S_MRSTG),
        .S_HOLD   (S_MRSTY),
        .S_INITOFF(S_INITOFF),
        .S_INITON (S_INITON)
    ) u_side_slot (
        .clk       (clk),
        .res       (res),
        .state     (state),
        .prev_state(prev_state),
        .press     (side_press),
        .req       (SLTReg),
        .served    (sideServed)
    );

endmodule

// File: doc/turn_request_latch.md
# turn_request_latch

Turn-lane request front end for the intersection controller. It synchronises and debounces the raw main-road and side-road left-turn sensor inputs, and latches each press as a sticky request. The requests drive the controller's MLTReg and SLTReg inputs. A request clears when the controller's 4-bit state shows that turn phase being served, and per-direction served counts are kept for the display and debug path.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronised input must hold a new level before it is accepted (10 ms at 100 MHz); minimum 2.
- S_MTGSR, 6: controller state code for main turn green.
- S_MTYSR, 7: controller state code for main turn yellow.
- S_MRSTG, 8: controller state code for side turn green.
- S_MRSTY, 9: controller state code for side turn yellow.
- S_INITOFF, 10: controller state code for init blink, lamps off.
- S_INITON, 11: controller state code for init blink, lamps on.

Ports:
- clk  in  1  system clock.
- res  in  1  reset; synchronous, active-high.
- mainBtn  in  1  raw main-road turn sensor; asynchronous, active-high.
- sideBtn  in  1  raw side-road turn sensor; asynchronous, active-high.
- state  in  4  controller state, registered on clk.
- MLTReg  out  1  main turn request pending.
- SLTReg  out  1  side turn request pending.
- mainServed  out  8  count of main turn phases served.
- sideServed  out  8  count of side turn phases served.

## Operation
- Per direction, an identical pipeline runs: 2-FF synchroniser, then debouncer, then rising-edge detector, then request latch.
- Debouncer:
  - Holds a stable level and a 32-bit counter.
  - When the synchronised input equals the stable level, the counter is forced to 0.
  - Otherwise the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, the stable level takes the synchronised value and the counter returns to 0.
  - Glitches shorter than DEBOUNCE_CYCLES are discarded.
- Press event: the stable level rises (stable & ~stable_d). Release events are ignored.
- Request latch, main direction (side uses S_MRSTG/S_MRSTY and SLTReg). Rules in priority order:
  1. state is S_INITOFF or S_INITON: MLTReg <= 0, and press events are dropped.
  2. state is S_MTGSR: MLTReg <= 0, because the phase is being served.
  3. state is S_MTYSR: press events are dropped and MLTReg holds.
  4. Otherwise a press event sets MLTReg <= 1. Further presses while it is set have no effect.
- Served counter: a registered previous-state copy is kept. When state == S_MTGSR and prev_state != S_MTGSR, mainServed increments by 1, wrapping 255 -> 0. The side counter does the same on S_MRSTG.
- Any other state code, including 12-15, is treated as an ordinary phase and applies rule 4.

## Timing
- Reset values: MLTReg=0, SLTReg=0, mainServed=0, sideServed=0. Synchroniser flops, stable levels, debounce counters, stable_d and prev_state are all 0.
- Reset asserted mid-debounce or with a request pending clears everything on the next edge. After res falls, a held button is re-qualified from scratch.
- Press latency: raw input goes high and stays high, first sampled at edge 1. The stable level rises at edge DEBOUNCE_CYCLES+2, and MLTReg rises at edge DEBOUNCE_CYCLES+3.
- Clear latency: MLTReg falls on the first edge at which state == S_MTGSR, i.e. one cycle after the controller enters the phase. The served counter updates on that same edge.
- A press event coinciding with a serve state code is dropped (clear wins). A press landing while state is S_MTYSR is lost and must be re-pressed after the phase ends.
- Outputs are registered with no combinational path from any input. MLTReg/SLTReg are stable for the controller's decision at S_MRSR2/S_MRSR1.
- Main and side are fully independent. Simultaneous presses both latch.

## Test plan
- Reset and debounce, DEBOUNCE_CYCLES=4:
  - Stimulus: reset, then mainBtn high at edge 1 and held.
  - Required: all outputs 0 after reset, and MLTReg=1 exactly at edge 7 with SLTReg=0.
- Glitch rejection, DEBOUNCE_CYCLES=4: mainBtn high for 3 cycles then low -> MLTReg remains 0 for 20 cycles.
- Serve clear, main then side:
  - Main: with MLTReg=1, drive state 6 for 5 cycles -> MLTReg=0 on the first edge and mainServed 0->1 (not 5).
  - Side: with SLTReg=1, drive state 8 for 5 cycles -> SLTReg=0 on the first edge and sideServed 0->1.
- Blocked windows:
  - A qualified sideBtn press while state=9 -> SLTReg stays 0.
  - A press while state=11 -> SLTReg stays 0.
  - A press while state=0 -> SLTReg=1.
- Counter wrap and reset mid-operation:
  - Enter state 6 from state 5 256 times -> mainServed returns to 0.
  - Then assert res with both requests set -> all outputs 0 next edge.
